// File: rtl/cc_pkg.sv
// Shared constants and FSM state type for the cache SRAM arbiter slice.
package cc_pkg;
  localparam int INDEX_W   = 9;
  localparam int TAG_W     = 18;
  localparam int LINE_W    = 512;
  localparam int NUM_LINES = 512;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } state_e;
endpackage

// File: rtl/cc_starve_counter.sv
// Counts consecutive denied read-request cycles, saturating at LIMIT.
module cc_starve_counter #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic rd_req_i,
  input  logic rd_gnt_i,
  output logic at_limit_o
);
  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      if (rd_gnt_i)                                cnt_d = '0;
      else if (rd_req_i && cnt_q != CW'(LIMIT))    cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign at_limit_o = (cnt_q == CW'(LIMIT));
endmodule

// File: rtl/cc_sram_arbiter.sv
// Single-port tag/data SRAM arbiter: lookup reads vs fill writes, plus a
// full-array invalidation sweep triggered by flush_i.
module cc_sram_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int INDEX_W      = cc_pkg::INDEX_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rd_req_i,
  input  logic [INDEX_W-1:0]        rd_index_i,
  output logic                      rd_gnt_o,
  input  logic                      wr_req_i,
  input  logic [INDEX_W-1:0]        wr_index_i,
  input  logic [cc_pkg::TAG_W-1:0]  wr_tag_i,
  input  logic [cc_pkg::LINE_W-1:0] wr_data_i,
  output logic                      wr_gnt_o,
  input  logic                      flush_i,
  output logic                      flush_busy_o,
  output logic                      flush_done_o,
  output logic                      sram_cs_o,
  output logic                      sram_we_o,
  output logic [INDEX_W-1:0]        sram_addr_o,
  output logic [cc_pkg::TAG_W-1:0]  sram_wtag_o,
  output logic [cc_pkg::LINE_W-1:0] sram_wdata_o,
  input  logic [cc_pkg::TAG_W-1:0]  sram_rtag_i,
  input  logic [cc_pkg::LINE_W-1:0] sram_rdata_i,
  output logic                      rd_valid_o,
  output logic [cc_pkg::TAG_W-1:0]  rd_tag_o,
  output logic [cc_pkg::LINE_W-1:0] rd_data_o
);
  import cc_pkg::*;

  state_e             state_q, state_d;
  logic [INDEX_W-1:0] flush_cnt_q, flush_cnt_d;
  logic               rd_valid_q, rd_valid_d;
  logic               idle, at_limit, rd_gnt, wr_gnt;

  // Grants are combinational; gating with rst keeps them low during reset.
  assign idle     = (state_q == IDLE) && !rst;
  assign rd_gnt   = idle && !flush_i && rd_req_i && (!wr_req_i || at_limit);
  assign wr_gnt   = idle && !flush_i && wr_req_i && !rd_gnt;
  assign rd_gnt_o = rd_gnt;
  assign wr_gnt_o = wr_gnt;

  cc_starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clk        (clk),
    .rst        (rst),
    .en_i       (idle),
    .rd_req_i   (rd_req_i),
    .rd_gnt_i   (rd_gnt),
    .at_limit_o (at_limit)
  );

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    rd_valid_d  = rd_gnt;
    case (state_q)
      IDLE:  if (flush_i) state_d = FLUSH;
      FLUSH: begin
        flush_cnt_d = flush_cnt_q + 1'b1;
        if (flush_cnt_q == INDEX_W'(NUM_LINES - 1)) begin
          state_d     = DONE;
          flush_cnt_d = '0;
        end
      end
      DONE: begin
        state_d     = IDLE;
        flush_cnt_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      flush_cnt_q <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  always_comb begin
    sram_cs_o    = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_wtag_o  = '0;
    sram_wdata_o = '0;
    if (state_q == FLUSH && !rst) begin
      sram_cs_o   = 1'b1;
      sram_we_o   = 1'b1;
      sram_addr_o = flush_cnt_q;
    end else if (rd_gnt) begin
      sram_cs_o   = 1'b1;
      sram_addr_o = rd_index_i;
    end else if (wr_gnt) begin
      sram_cs_o    = 1'b1;
      sram_we_o    = 1'b1;
      sram_addr_o  = wr_index_i;
      sram_wtag_o  = wr_tag_i;
      sram_wdata_o = wr_data_i;
    end
  end

  assign flush_busy_o = (state_q != IDLE) && !rst;
  assign flush_done_o = (state_q == DONE) && !rst;
  assign rd_valid_o   = rd_valid_q;
  assign rd_tag_o     = sram_rtag_i;
  assign rd_data_o    = sram_rdata_i;
endmodule

// File: tb/tb_cc_sram_arbiter.sv
// Directed bench with a per-cycle behavioural model of arbitration, flush and SRAM contents.
module tb_cc_sram_arbiter;
  localparam int LIMIT = 4;
  localparam int N     = 512;

  logic         clk = 1'b0, rst = 1'b1;
  logic         rd_req_i = 1'b0, wr_req_i = 1'b0, flush_i = 1'b0;
  logic [8:0]   rd_index_i = '0, wr_index_i = '0;
  logic [17:0]  wr_tag_i = '0;
  logic [511:0] wr_data_i = '0;
  logic         rd_gnt_o, wr_gnt_o, flush_busy_o, flush_done_o;
  logic         sram_cs_o, sram_we_o, rd_valid_o;
  logic [8:0]   sram_addr_o;
  logic [17:0]  sram_wtag_o, sram_rtag_i, rd_tag_o;
  logic [511:0] sram_wdata_o, sram_rdata_i, rd_data_o;

  int n_chk = 0, n_fail = 0;

  cc_sram_arbiter #(.STARVE_LIMIT(LIMIT), .INDEX_W(9)) dut (
    .clk(clk), .rst(rst),
    .rd_req_i(rd_req_i), .rd_index_i(rd_index_i), .rd_gnt_o(rd_gnt_o),
    .wr_req_i(wr_req_i), .wr_index_i(wr_index_i), .wr_tag_i(wr_tag_i),
    .wr_data_i(wr_data_i), .wr_gnt_o(wr_gnt_o),
    .flush_i(flush_i), .flush_busy_o(flush_busy_o), .flush_done_o(flush_done_o),
    .sram_cs_o(sram_cs_o), .sram_we_o(sram_we_o), .sram_addr_o(sram_addr_o),
    .sram_wtag_o(sram_wtag_o), .sram_wdata_o(sram_wdata_o),
    .sram_rtag_i(sram_rtag_i), .sram_rdata_i(sram_rdata_i),
    .rd_valid_o(rd_valid_o), .rd_tag_o(rd_tag_o), .rd_data_o(rd_data_o)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [511:0] act, logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Environment SRAM (single port, one-cycle read latency)
  logic [17:0]  mem_tag [N];
  logic [511:0] mem_dat [N];
  always @(posedge clk) begin
    if (sram_cs_o) begin
      if (sram_we_o) begin
        mem_tag[sram_addr_o] <= sram_wtag_o;
        mem_dat[sram_addr_o] <= sram_wdata_o;
      end else begin
        sram_rtag_i  <= mem_tag[sram_addr_o];
        sram_rdata_i <= mem_dat[sram_addr_o];
      end
    end
  end

  // Behavioural model: flush position (-1 = not sweeping), done pulse, starve count,
  // expected array contents and the one read response in flight.
  int           f_idx = -1;
  bit           f_done = 0;
  int           starve = 0;
  bit           rd_pend = 0;
  logic [17:0]  pend_tag;
  logic [511:0] pend_dat;
  logic [17:0]  exp_tag [N];
  logic [511:0] exp_dat [N];

  always @(negedge clk) begin
    bit e_rg, e_wg, e_cs, e_we, busy;
    logic [8:0] e_addr;
    logic [17:0] e_wtag;
    logic [511:0] e_wdat;
    e_rg = 0; e_wg = 0; e_cs = 0; e_we = 0; e_addr = '0; e_wtag = '0; e_wdat = '0;
    if (rst) begin
      chk("rst rd_gnt", 512'(rd_gnt_o), 512'(0));
      chk("rst wr_gnt", 512'(wr_gnt_o), 512'(0));
      chk("rst cs", 512'(sram_cs_o), 512'(0));
      chk("rst busy", 512'(flush_busy_o), 512'(0));
      chk("rst done", 512'(flush_done_o), 512'(0));
      chk("rst rd_valid", 512'(rd_valid_o), 512'(0));
      f_idx = -1; f_done = 0; starve = 0; rd_pend = 0;
    end else begin
      busy = (f_idx >= 0) || f_done;
      if (f_idx >= 0) begin
        e_cs = 1; e_we = 1; e_addr = 9'(f_idx);
      end else if (!f_done && !flush_i) begin
        if (rd_req_i && (!wr_req_i || starve == LIMIT)) begin
          e_rg = 1; e_cs = 1; e_addr = rd_index_i;
        end else if (wr_req_i) begin
          e_wg = 1; e_cs = 1; e_we = 1; e_addr = wr_index_i; e_wtag = wr_tag_i; e_wdat = wr_data_i;
        end
      end
      chk("rd_gnt", 512'(rd_gnt_o), 512'(e_rg));
      chk("wr_gnt", 512'(wr_gnt_o), 512'(e_wg));
      chk("sram_cs", 512'(sram_cs_o), 512'(e_cs));
      chk("busy", 512'(flush_busy_o), 512'(busy));
      chk("done", 512'(flush_done_o), 512'(f_done));
      chk("rd_valid", 512'(rd_valid_o), 512'(rd_pend));
      if (e_cs) begin
        chk("sram_we", 512'(sram_we_o), 512'(e_we));
        chk("sram_addr", 512'(sram_addr_o), 512'(e_addr));
      end
      if (e_we) begin
        chk("sram_wtag", 512'(sram_wtag_o), 512'(e_wtag));
        chk("sram_wdata", sram_wdata_o, e_wdat);
      end
      if (rd_pend) begin
        chk("rd_tag", 512'(rd_tag_o), 512'(pend_tag));
        chk("rd_data", rd_data_o, pend_dat);
      end
      // advance model to the next cycle
      rd_pend = e_rg;
      if (e_rg) begin pend_tag = exp_tag[e_addr]; pend_dat = exp_dat[e_addr]; end
      if (e_we) begin exp_tag[e_addr] = e_wtag; exp_dat[e_addr] = e_wdat; end
      if (!busy) begin
        if (e_rg) starve = 0;
        else if (rd_req_i && starve < LIMIT) starve++;
      end
      if (f_done) f_done = 0;
      else if (f_idx == N - 1) begin f_idx = -1; f_done = 1; end
      else if (f_idx >= 0) f_idx++;
      else if (flush_i) f_idx = 0;
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    bit [9:0] pat;
    bit [N-1:0] seen;
    int done_k, nwr, ngnt, ndone;
    bit tag_bad;
    for (int i = 0; i < N; i++) begin
      mem_tag[i] = 18'h00100 | 18'(i);
      mem_dat[i] = {16{32'hA5000000 | 32'(i)}};
      exp_tag[i] = mem_tag[i];
      exp_dat[i] = mem_dat[i];
    end
    repeat (3) cyc();
    rst = 0;
    cyc();

    // lone read of index 5
    rd_req_i = 1; rd_index_i = 9'd5;
    @(negedge clk);
    chk("t1 rd_gnt", 512'(rd_gnt_o), 512'(1));
    chk("t1 addr", 512'(sram_addr_o), 512'(5));
    cyc(); rd_req_i = 0;
    @(negedge clk);
    chk("t1 rd_valid", 512'(rd_valid_o), 512'(1));
    chk("t1 rd_tag", 512'(rd_tag_o), 512'(18'h00105));
    chk("t1 rd_data", 512'(rd_data_o[31:0]), 512'(32'hA5000005));

    // both requests held: W,W,W,W,R repeating
    cyc();
    rd_req_i = 1; rd_index_i = 9'd2; wr_req_i = 1; wr_index_i = 9'd3;
    wr_tag_i = 18'h20033; wr_data_i = {16{32'h33333333}};
    pat = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      pat[k] = rd_gnt_o;
      cyc();
    end
    chk("t2 grant pattern", 512'(pat), 512'(10'h210));
    rd_req_i = 0; wr_req_i = 0;

    // write index 7 then read it back
    cyc();
    wr_req_i = 1; wr_index_i = 9'd7; wr_tag_i = 18'h20001; wr_data_i = {16{32'hCAFE0007}};
    cyc(); wr_req_i = 0; rd_req_i = 1; rd_index_i = 9'd7;
    cyc(); rd_req_i = 0;
    @(negedge clk);
    chk("t3 rd_tag", 512'(rd_tag_o), 512'(18'h20001));

    // flush sweep with a read request pending throughout
    cyc();
    flush_i = 1; rd_req_i = 1; rd_index_i = 9'd7;
    seen = '0; done_k = 0; nwr = 0; ngnt = 0; tag_bad = 0;
    for (int k = 1; k <= 600; k++) begin
      @(negedge clk);
      if (done_k != 0 && k == done_k + 1) begin
        chk("t4 rd_gnt after done", 512'(rd_gnt_o), 512'(1));
        break;
      end
      if (sram_cs_o && sram_we_o) begin
        nwr++; seen[sram_addr_o] = 1'b1;
        if (sram_wtag_o != 18'h0) tag_bad = 1;
      end
      if (rd_gnt_o || wr_gnt_o) ngnt++;
      if (flush_done_o) done_k = k;
      cyc(); flush_i = 0;
    end
    chk("t4 done cycle", 512'(done_k), 512'(514));
    chk("t4 writes", 512'(nwr), 512'(512));
    chk("t4 coverage", 512'(seen), {N{1'b1}});
    chk("t4 grants", 512'(ngnt), 512'(0));
    chk("t4 zero tags", 512'(tag_bad), 512'(0));
    cyc(); rd_req_i = 0;

    // read granted right before flush; flush re-pulsed mid-sweep
    cyc();
    rd_req_i = 1; rd_index_i = 9'd4;
    @(negedge clk);
    chk("t5 rd_gnt", 512'(rd_gnt_o), 512'(1));
    cyc(); rd_req_i = 0; flush_i = 1;
    @(negedge clk);
    chk("t5 rd_valid at flush", 512'(rd_valid_o), 512'(1));
    chk("t5 rd_tag flushed", 512'(rd_tag_o), 512'(0));
    cyc(); flush_i = 0;
    nwr = 0; ndone = 0;
    for (int k = 0; k < 700; k++) begin
      @(negedge clk);
      if (sram_cs_o && sram_we_o) nwr++;
      if (flush_done_o) ndone++;
      cyc();
      flush_i = (k == 99);
    end
    flush_i = 0;
    chk("t5 writes", 512'(nwr), 512'(512));
    chk("t5 done pulses", 512'(ndone), 512'(1));

    // reset in the middle of a flush
    cyc(); flush_i = 1;
    cyc(); flush_i = 0;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (sram_cs_o && sram_addr_o == 9'd200) break;
    end
    chk("t6 reached 200", 512'(sram_addr_o), 512'(200));
    #1 rst = 1;
    #1;
    chk("t6 busy immediate", 512'(flush_busy_o), 512'(0));
    chk("t6 cs immediate", 512'(sram_cs_o), 512'(0));
    repeat (2) cyc();
    rst = 0;
    cyc();
    rd_req_i = 1; rd_index_i = 9'd9;
    @(negedge clk);
    chk("t6 rd_gnt after rst", 512'(rd_gnt_o), 512'(1));
    cyc(); rd_req_i = 0;
    ndone = 0;
    for (int k = 0; k < 520; k++) begin
      @(negedge clk);
      if (flush_done_o) ndone++;
      cyc();
    end
    chk("t6 no done", 512'(ndone), 512'(0));

    repeat (2) cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
